// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode pipeline: opcodes, instruction
// field positions and the fetch-stage state encoding.
package isa_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_BNE = 4'd14;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RS_HI  = 11;
    localparam int RS_LO  = 8;
    localparam int RT_HI  = 7;
    localparam int RT_LO  = 4;
    localparam int RD_HI  = 3;
    localparam int RD_LO  = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    function automatic logic [3:0] opc_of(input logic [15:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset, redirect load and increment,
// with priority rst > load > increment.
module fetch_pc_reg #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_pc;
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives a req/ack handshake to instruction memory, buffers one
// instruction for the decoder and squashes wrong-path fetches on a redirect.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [3:0]         out_opCode,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  drop_pc_q, drop_pc_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;

    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load),
        .load_pc (redirect_pc),
        .inc_en  (pc_inc),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    // Without the ack the request is still open and must be
                    // completed at its original address before refetching.
                    state_d = imem_ack ? ST_FETCH : ST_DROP;
                end else if (imem_ack) begin
                    pc_inc  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end else if (out_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                pc_load = redirect_valid;
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        drop_pc_d   = drop_pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        unique case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (!imem_ack) begin
                        drop_pc_d = pc;
                    end
                end else if (imem_ack) begin
                    out_valid_d = 1'b1;
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pc_q   <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            drop_pc_q   <= drop_pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_req   = (state_q == ST_FETCH || state_q == ST_DROP) && !rst;
    assign imem_addr  = (state_q == ST_DROP) ? drop_pc_q : pc;
    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_pc     = out_pc_q;
    assign out_opCode = out_instr_q[OPC_HI:OPC_LO];

endmodule
